// File: rtl/snd_pkg.sv
// Shared constants, FSM state type and SN76489 byte-field helpers for the
// sound-chip write arbiter.
package snd_pkg;

  localparam logic [2:0] ADR_T1    = 3'd0;
  localparam logic [2:0] ADR_A1    = 3'd1;
  localparam logic [2:0] ADR_T2    = 3'd2;
  localparam logic [2:0] ADR_A2    = 3'd3;
  localparam logic [2:0] ADR_T3    = 3'd4;
  localparam logic [2:0] ADR_A3    = 3'd5;
  localparam logic [2:0] ADR_NOISE = 3'd6;
  localparam logic [2:0] ADR_A4    = 3'd7;

  localparam logic [3:0] ATT_OFF = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  function automatic logic is_latch(input logic [7:0] b);
    return b[7];
  endfunction

  function automatic logic [2:0] latch_adr(input logic [7:0] b);
    return b[6:4];
  endfunction

  // Tone registers take their upper six bits from data bytes.
  function automatic logic is_tone_adr(input logic [2:0] a);
    return (a[0] == 1'b0) && (a != ADR_NOISE);
  endfunction

  function automatic logic [9:0] shadow_rst(input logic [2:0] a);
    return a[0] ? {6'd0, ATT_OFF} : 10'd0;
  endfunction

endpackage

// File: rtl/snd_byte_decode.sv
// Combinational SN76489 byte decoder: applies one latch/data byte to the
// requester's latched address and the shadow entry it targets.
module snd_byte_decode
  import snd_pkg::*;
(
  input  logic [7:0] byte_i,
  input  logic [2:0] adr_i,
  input  logic [9:0] entry_i,
  output logic [2:0] adr_o,
  output logic [9:0] entry_o,
  output logic       is_noise_o
);

  always_comb begin
    adr_o   = adr_i;
    entry_o = entry_i;
    if (is_latch(byte_i)) begin
      adr_o   = latch_adr(byte_i);
      entry_o = {entry_i[9:4], byte_i[3:0]};
    end else if (is_tone_adr(adr_i)) begin
      entry_o = {byte_i[5:0], entry_i[3:0]};
    end else begin
      entry_o = {entry_i[9:4], byte_i[3:0]};
    end
    is_noise_o = (adr_o == ADR_NOISE);
  end

endmodule

// File: rtl/snd_write_arbiter.sv
// Two-requester write arbiter for the sound control_reg port with shadow file.
// Optional macro SNDARB_FIXED_PRIO_EN: requester 0 always wins, no RR pointer.
module snd_write_arbiter
  import snd_pkg::*;
#(
  parameter int LOAD_GAP = 4,
  parameter int GAP_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [2:0] adress,
  output logic [9:0] value,
  output logic       load,
  output logic       noise_rst,
  output logic       busy
);

  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(LOAD_GAP);

  state_e           state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [2:0]       ctx_q [2];
  logic [2:0]       ctx_d [2];
  logic [9:0]       shadow_q [8];
  logic [9:0]       shadow_d [8];
  logic [2:0]       adress_q, adress_d;
  logic [9:0]       value_q, value_d;
  logic             load_q, load_d;
  logic             noise_rst_q, noise_rst_d;
  logic             busy_q, busy_d;

  logic             gnt0_s, gnt1_s, hs_s, sel_s;
  logic [7:0]       sel_byte_s;
  logic [2:0]       sel_ctx_s, tgt_adr_s, new_adr_s;
  logic [9:0]       cur_entry_s, new_entry_s;
  logic             new_noise_s;

`ifndef SNDARB_FIXED_PRIO_EN
  logic             rr_q, rr_d;
`endif

  // Grants only exist in IDLE and outside reset; each one already implies valid.
  always_comb begin
`ifdef SNDARB_FIXED_PRIO_EN
    gnt0_s = req0_valid;
    gnt1_s = req1_valid && !req0_valid;
`else
    gnt0_s = req0_valid && (!rr_q || !req1_valid);
    gnt1_s = req1_valid && (rr_q || !req0_valid);
`endif
    if ((state_q != ST_IDLE) || !rst_n) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      gnt0_s = gnt0_s;
      gnt1_s = gnt1_s;
    end
  end

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;
  assign hs_s       = gnt0_s | gnt1_s;
  assign sel_s      = gnt1_s;

  assign sel_byte_s  = sel_s ? req1_data : req0_data;
  assign sel_ctx_s   = sel_s ? ctx_q[1] : ctx_q[0];
  assign tgt_adr_s   = is_latch(sel_byte_s) ? latch_adr(sel_byte_s) : sel_ctx_s;
  assign cur_entry_s = shadow_q[tgt_adr_s];

  snd_byte_decode u_decode (
    .byte_i     (sel_byte_s),
    .adr_i      (sel_ctx_s),
    .entry_i    (cur_entry_s),
    .adr_o      (new_adr_s),
    .entry_o    (new_entry_s),
    .is_noise_o (new_noise_s)
  );

  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    ctx_d       = ctx_q;
    shadow_d    = shadow_q;
    adress_d    = adress_q;
    value_d     = value_q;
    load_d      = 1'b0;
    noise_rst_d = 1'b0;
`ifndef SNDARB_FIXED_PRIO_EN
    rr_d        = rr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (hs_s) begin
          state_d             = ST_COMMIT;
          adress_d            = new_adr_s;
          // Only the three noise-control bits are meaningful on the port.
          value_d             = new_noise_s ? {7'd0, new_entry_s[2:0]} : new_entry_s;
          load_d              = 1'b1;
          noise_rst_d         = new_noise_s;
          shadow_d[new_adr_s] = new_entry_s;
          ctx_d[sel_s]        = new_adr_s;
`ifndef SNDARB_FIXED_PRIO_EN
          rr_d                = ~sel_s;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        if (LOAD_GAP > 0) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_INIT;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gap_cnt_q   <= '0;
      ctx_q[0]    <= ADR_T1;
      ctx_q[1]    <= ADR_T1;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= shadow_rst(3'(i));
      end
      adress_q    <= 3'd0;
      value_q     <= 10'd0;
      load_q      <= 1'b0;
      noise_rst_q <= 1'b0;
      busy_q      <= 1'b0;
`ifndef SNDARB_FIXED_PRIO_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      ctx_q       <= ctx_d;
      shadow_q    <= shadow_d;
      adress_q    <= adress_d;
      value_q     <= value_d;
      load_q      <= load_d;
      noise_rst_q <= noise_rst_d;
      busy_q      <= busy_d;
`ifndef SNDARB_FIXED_PRIO_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign adress    = adress_q;
  assign value     = value_q;
  assign load      = load_q;
  assign noise_rst = noise_rst_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_snd_write_arbiter.sv
// Self-checking bench for snd_write_arbiter: directed vector table, reset and
// contention sequences, then randomized traffic against a reference model.
module tb_snd_write_arbiter;

  localparam int G = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req0_data, req1_data;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [2:0] adress;
  logic [9:0] value;
  logic       load, noise_rst, busy;

  always #5 clk = ~clk;

  snd_write_arbiter #(.LOAD_GAP(G), .GAP_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_data  (req0_data),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req1_data  (req1_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .adress     (adress),
    .value      (value),
    .load       (load),
    .noise_rst  (noise_rst),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0] a;
    logic [9:0] v;
    logic       nr;
  } exp_t;

  logic [9:0] m_sh [8];
  logic [2:0] m_ctx [2];
  int         m_rr = 0;
  int         cyc = 0;
  int         last_hs = -100;
  exp_t       exp_q [$];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_sh[i] = (i % 2 == 1) ? 10'h00F : 10'h000;
    m_ctx[0] = 3'd0;
    m_ctx[1] = 3'd0;
    m_rr     = 0;
    last_hs  = -100;
    exp_q.delete();
  endtask

  task automatic model_apply(input int r, input logic [7:0] b);
    exp_t       e;
    logic [2:0] a;
    if (b[7]) begin
      m_ctx[r]      = b[6:4];
      a             = m_ctx[r];
      m_sh[a][3:0]  = b[3:0];
    end else begin
      a = m_ctx[r];
      if (a == 3'd0 || a == 3'd2 || a == 3'd4) m_sh[a][9:4] = b[5:0];
      else                                       m_sh[a][3:0] = b[3:0];
    end
    e.a  = a;
    e.nr = (a == 3'd6);
    e.v  = e.nr ? (m_sh[a] & 10'h007) : m_sh[a];
    exp_q.push_back(e);
  endtask

  // Continuous scoreboard: loads, busy and grant legality every cycle.
  always @(negedge clk) begin
    exp_t e;
    int   r;
    logic avail, e_r0, e_r1;
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mon_load", load, 1);
        chk("mon_adress", adress, e.a);
        chk("mon_value", value, e.v);
        chk("mon_noise_rst", noise_rst, e.nr);
      end else begin
        chk("mon_no_load", load, 0);
        chk("mon_no_noise_rst", noise_rst, 0);
      end
      chk("mon_busy", busy, (cyc > last_hs) && (cyc < last_hs + G + 2));
      avail = (cyc >= last_hs + G + 2);
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      if (avail && req0_valid && req1_valid) begin
`ifdef SNDARB_FIXED_PRIO_EN
        e_r0 = 1'b1;
`else
        e_r0 = (m_rr == 0);
        e_r1 = (m_rr == 1);
`endif
      end else if (avail) begin
        e_r0 = req0_valid;
        e_r1 = req1_valid;
      end
      chk("mon_req0_ready", req0_ready, e_r0);
      chk("mon_req1_ready", req1_ready, e_r1);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        r = (req1_valid && req1_ready) ? 1 : 0;
        model_apply(r, r == 1 ? req1_data : req0_data);
        last_hs = cyc;
        m_rr    = 1 - r;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int r, input logic [7:0] d);
    int n = 0;
    @(posedge clk); #1;
    if (r == 0) begin req0_data = d; req0_valid = 1'b1; end
    else        begin req1_data = d; req1_valid = 1'b1; end
    @(negedge clk);
    while (!((r == 0) ? req0_ready : req1_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("handshake_in_time", (n < 50), 1);
    @(posedge clk); #1;
    if (r == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int         r;
    logic [7:0] d;
    logic [2:0] a;
    logic [9:0] v;
    logic       nr;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int   prev_g, prev_c, ng, g;
    logic h0, h1;

    vecs[0]  = '{0, 8'h8E, 3'd0, 10'h00E, 1'b0};
    vecs[1]  = '{0, 8'h0F, 3'd0, 10'h0FE, 1'b0};
    vecs[2]  = '{1, 8'h95, 3'd1, 10'h005, 1'b0};
    vecs[3]  = '{1, 8'h03, 3'd1, 10'h003, 1'b0};
    vecs[4]  = '{0, 8'hE5, 3'd6, 10'h005, 1'b1};
    vecs[5]  = '{0, 8'hC3, 3'd4, 10'h003, 1'b0};
    vecs[6]  = '{1, 8'hB2, 3'd3, 10'h002, 1'b0};
    vecs[7]  = '{0, 8'h3F, 3'd4, 10'h3F3, 1'b0};
    vecs[8]  = '{0, 8'hE7, 3'd6, 10'h007, 1'b1};
    vecs[9]  = '{0, 8'h7D, 3'd6, 10'h005, 1'b1};
    vecs[10] = '{0, 8'h86, 3'd0, 10'h0F6, 1'b0};
    vecs[11] = '{0, 8'h41, 3'd0, 10'h016, 1'b0};
    vecs[12] = '{1, 8'h0A, 3'd3, 10'h00A, 1'b0};
    vecs[13] = '{1, 8'hFF, 3'd7, 10'h00F, 1'b0};
    vecs[14] = '{1, 8'h51, 3'd7, 10'h001, 1'b0};

    rst_n = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #12;
    chk("rst_adress", adress, 0);
    chk("rst_value", value, 0);
    chk("rst_load", load, 0);
    chk("rst_noise_rst", noise_rst, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      send(vecs[i].r, vecs[i].d);
      chk($sformatf("vec%0d_load", i), load, 1);
      chk($sformatf("vec%0d_adress", i), adress, vecs[i].a);
      chk($sformatf("vec%0d_value", i), value, vecs[i].v);
      chk($sformatf("vec%0d_noise_rst", i), noise_rst, vecs[i].nr);
    end

    // Reset during GAP with a byte pending, then first data byte uses R=0.
    send(0, 8'h91);
    @(posedge clk); #2;
    req0_data = 8'h05; req0_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("gap_rst_adress", adress, 0);
    chk("gap_rst_value", value, 0);
    chk("gap_rst_load", load, 0);
    chk("gap_rst_busy", busy, 0);
    chk("gap_rst_req0_ready", req0_ready, 0);
    req0_valid = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    send(0, 8'h05);
    chk("post_rst_adress", adress, 0);
    chk("post_rst_value", value, 10'h050);

    // Reset during COMMIT cuts the load and clears context 1.
    send(1, 8'hB7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("commit_rst_load", load, 0);
    chk("commit_rst_value", value, 0);
    @(negedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    send(1, 8'h03);
    chk("commit_rst_adress", adress, 0);
    chk("commit_rst_value2", value, 10'h030);

    // Continuous contention.
    @(posedge clk); #1;
    req0_data = 8'($urandom); req1_data = 8'($urandom);
    req0_valid = 1'b1; req1_valid = 1'b1;
    prev_g = -1; prev_c = -1; ng = 0;
    for (int c = 0; c < 62; c++) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      if (h0 || h1) begin
        g = h1 ? 1 : 0;
`ifdef SNDARB_FIXED_PRIO_EN
        chk("fixed_prio_grant", g, 0);
`else
        if (prev_g >= 0) chk("rr_alternate", g, 1 - prev_g);
`endif
        if (prev_c >= 0) chk("contention_spacing", c - prev_c, G + 2);
        prev_g = g; prev_c = c; ng++;
      end
      @(posedge clk); #1;
      if (h0) req0_data = 8'($urandom);
      if (h1) req1_data = 8'($urandom);
    end
    chk("contention_grant_count", (ng >= 9), 1);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Randomized traffic, checked by the scoreboard.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (h0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_data  = 8'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        req0_valid = 1'b0;
      end
      if (h1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_data  = 8'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        req1_valid = 1'b0;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
